lc3_mem_ctrl: RTL and testbench
===============================

# lc3_mem_ctrl

Initiator-side controller for the LC-3 unified memory, which reads combinationally from the address register and writes on the clock edge under write enable. It accepts single load/store requests from the datapath, drives MAR, MDR and the memory write enable, samples read data after a configurable number of wait states, and returns one response per request. It sits between the control unit/datapath and the memory array and owns every memory cycle.

## Interface
- WAIT_STATES, 1: extra cycles between MAR load and the access cycle (0..15)
- MEM_DEPTH, 256: number of implemented memory words

- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  16  word address
- req_wdata  input  16  store data
- rsp_valid  output  1  response present
- rsp_ready  input  1  datapath accepts response
- rsp_data  output  16  load data; store data echoed on stores
- rsp_err  output  1  out-of-range access (see Configuration)
- MARReg  output  16  memory address register
- mdrOut  output  16  memory data register (write data)
- memWE  output  1  memory write enable
- memOut  input  16  combinational memory read data

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid: MARReg<=req_addr, mdrOut<=req_wdata (loads leave mdrOut unchanged), latch req_we; go to WAIT if WAIT_STATES>0, else ACCESS.
- WAIT: 4-bit counter loaded with WAIT_STATES-1 on entry, decrements each cycle; at 0 go to ACCESS.
- ACCESS (exactly one cycle): store → memWE=1, memory commits mdrOut at MARReg at the closing edge, rsp_data<=mdrOut. Load → rsp_data<=memOut. Go to RESP.
- RESP: rsp_valid=1, rsp_data/rsp_err stable; on rsp_ready go to IDLE. No new request is accepted in RESP (req_ready=0); back-to-back requests cost one IDLE cycle.
- memWE is combinational: (state==ACCESS) & stored_we & reset & ~range_err. It is never high outside ACCESS.
- MARReg and mdrOut hold their values after the transaction until the next accepted request.
- req_* inputs are ignored in every state except IDLE.

## Timing
- Request accepted at edge 0; ACCESS occupies cycle 1+WAIT_STATES; rsp_valid rises at edge 2+WAIT_STATES. Default latency: 3 cycles.
- Reset values: state IDLE, MARReg=0, mdrOut=0, memWE=0, rsp_valid=0, rsp_data=0, rsp_err=0, counter=0. req_ready=0 while reset is low.
- Reset mid-operation: the transaction is abandoned and no response is produced. If reset is low during ACCESS, memWE is suppressed combinationally and no write occurs.
- rsp_valid held with rsp_ready=0: the controller stays in RESP indefinitely with rsp_data unchanged.
- rsp_ready high outside RESP: ignored.

## Configuration
- LC3_MEM_CTRL_BOUNDS_EN defined: at acceptance, req_addr>=MEM_DEPTH sets range_err. The request still walks the full FSM with identical latency, but memWE stays 0. Response carries rsp_err=1 and rsp_data=16'hFFFF.
- Undefined: no range check. rsp_err is tied to 0 and every address is passed to memory unmodified. The port list is identical in both builds.

## Structure
- Shared package lc3_mem_pkg holds the state enum (IDLE, WAIT, ACCESS, RESP), the MEM_DEPTH default, and the 16'hFFFF error-data constant.
- One sub-module is natural: lc3_wait_timer (load, decrement, done flag), instantiated for the WAIT state.

## Test plan
- Store 16'h1234 to 16'h0010 with WAIT_STATES=1 → memWE high for exactly one cycle, at cycle 2; rsp_valid at cycle 3 with rsp_data=16'h1234; memory[0x10]=16'h1234.
- Load from 16'h0010 after that store → rsp_data=16'h1234, rsp_err=0, memWE stays 0 throughout.
- Hold rsp_ready=0 for 5 cycles in RESP while driving a new req_valid → req_ready=0 and rsp_data stable; on release, the new request is accepted one cycle after RESP exits.
- Drop reset during the ACCESS cycle of a store to 16'h0020 → memWE=0; memory[0x20] retains its prior value (16'hFFFF after init); all outputs return to their reset values.
- With LC3_MEM_CTRL_BOUNDS_EN, store to 16'h0100 → no memWE pulse; response rsp_err=1, rsp_data=16'hFFFF. Without the macro: memWE pulses and rsp_err=0.
- WAIT_STATES=0 versus 3 → rsp_valid arrives 2 versus 5 cycles after acceptance.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared definitions for the LC-3 memory controller: state encodings, default depth, error data.
// Consumers: lc3_wait_timer, lc3_mem_ctrl (optional range check via LC3_MEM_CTRL_BOUNDS_EN).
package lc3_mem_pkg;

  localparam int MEM_DEPTH_DEFAULT = 256;
  localparam logic [15:0] ERR_DATA = 16'hFFFF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/lc3_wait_timer.sv
// Down-counter that paces the WAIT state: loaded on request acceptance, counts while enabled,
// and flags done once it reaches zero.
module lc3_wait_timer
  import lc3_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       en,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/lc3_mem_ctrl.sv
// Initiator-side controller for the LC-3 unified memory: one load/store per request, fixed latency.
// Define LC3_MEM_CTRL_BOUNDS_EN to flag and suppress accesses at or beyond MEM_DEPTH.
module lc3_mem_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [15:0] MARReg,
  output logic [15:0] mdrOut,
  output logic        memWE,
  input  logic [15:0] memOut
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam state_t     ST_AFTER_ACCEPT = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;

  state_t state;
  logic   stored_we;
  logic   range_err;
  logic   rsp_err_q;
  logic   timer_done;
  logic   accept;

  assign accept = (state == ST_IDLE) && req_valid;

  lc3_wait_timer u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (accept),
    .load_value (WAIT_LOAD),
    .en         (state == ST_WAIT),
    .done       (timer_done)
  );

`ifdef LC3_MEM_CTRL_BOUNDS_EN
  logic addr_oob;

  assign addr_oob = ({16'd0, req_addr} >= 32'(MEM_DEPTH));

  always_ff @(posedge clk) begin
    if (!reset) begin
      range_err <= 1'b0;
    end else if (accept) begin
      range_err <= addr_oob;
    end
  end
`else
  localparam int unused_depth = MEM_DEPTH;

  assign range_err = 1'b0;
`endif

  // MARReg/mdrOut persist after the transaction so the memory sees a stable address between requests.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      MARReg    <= 16'd0;
      mdrOut    <= 16'd0;
      stored_we <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            MARReg    <= req_addr;
            stored_we <= req_we;
            if (req_we) begin
              mdrOut <= req_wdata;
            end
            state <= ST_AFTER_ACCEPT;
          end
        end
        ST_WAIT: begin
          if (timer_done) begin
            state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (range_err) begin
            rsp_data <= ERR_DATA;
          end else if (stored_we) begin
            rsp_data <= mdrOut;
          end else begin
            rsp_data <= memOut;
          end
          rsp_err_q <= range_err;
          state     <= ST_RESP;
        end
        default: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  // Gating with reset kills a write combinationally even in the ACCESS cycle itself.
  assign memWE     = (state == ST_ACCESS) && stored_we && reset && !range_err;
  assign req_ready = (state == ST_IDLE) && reset;
  assign rsp_valid = (state == ST_RESP) && reset;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl: three instances (WAIT_STATES 0/1/3) share stimulus, each with its own memory.
// Expected responses are queued at request time and checked as each instance responds.
module tb_lc3_mem_ctrl;
  import lc3_mem_pkg::*;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
    logic        we;
  } exp_t;

  logic clk;
  logic reset;
  logic req_valid;
  logic req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic rsp_ready;

  logic [NDUT-1:0] req_ready;
  logic [NDUT-1:0] rsp_valid;
  logic [NDUT-1:0] rsp_err;
  logic [NDUT-1:0] mem_we;
  logic [15:0] rsp_data [NDUT];
  logic [15:0] mar [NDUT];
  logic [15:0] mdr [NDUT];
  logic [15:0] mem_out [NDUT];

  exp_t sb [$];
  logic [15:0] model [256];
  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    logic [15:0] mem [256];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    end

    always @(posedge clk) begin
      if (mem_we[g]) mem[mar[g][7:0]] <= mdr[g];
    end

    assign mem_out[g] = mem[mar[g][7:0]];

    lc3_mem_ctrl #(
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 3)),
      .MEM_DEPTH   (256)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready[g]),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data[g]),
      .rsp_err   (rsp_err[g]),
      .MARReg    (mar[g]),
      .mdrOut    (mdr[g]),
      .memWE     (mem_we[g]),
      .memOut    (mem_out[g])
    );
  end

  function automatic int wsOf(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives a request at the current (negedge) time and queues the response it should produce.
  task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    exp_t e;
    logic oob;
    oob = 1'b0;
`ifdef LC3_MEM_CTRL_BOUNDS_EN
    oob = (addr >= 16'd256);
`endif
    e.err = oob;
    e.we  = we && !oob;
    if (oob) e.data = 16'hFFFF;
    else if (we) e.data = wdata;
    else e.data = model[addr[7:0]];
    if (e.we) model[addr[7:0]] = wdata;
    sb.push_back(e);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  // c0 = number of negedges already elapsed since the request was first presented.
  task automatic collectResponses(input int c0);
    exp_t e;
    int lat [NDUT];
    int we_cnt [NDUT];
    int we_at;
    logic [NDUT-1:0] seen;
    e = sb[0];
    seen = '0;
    we_at = -1;
    for (int g = 0; g < NDUT; g++) begin
      lat[g] = -1;
      we_cnt[g] = 0;
    end
    for (int c = c0; (c < c0 + 20) && (seen != '1); c++) begin
      for (int g = 0; g < NDUT; g++) begin
        if (mem_we[g]) begin
          we_cnt[g]++;
          if (g == 1) we_at = c;
        end
        if (rsp_valid[g] && !seen[g]) begin
          seen[g] = 1'b1;
          lat[g] = c;
          checkOutput($sformatf("rsp_data[%0d]", g), rsp_data[g], e.data);
          checkOutput($sformatf("rsp_err[%0d]", g), {15'd0, rsp_err[g]}, {15'd0, e.err});
        end
      end
      @(negedge clk);
    end
    void'(sb.pop_front());
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("responded[%0d]", g), {15'd0, seen[g]}, 16'd1);
      checkOutput($sformatf("latency[%0d]", g), 16'(lat[g]), 16'(2 + wsOf(g)));
      checkOutput($sformatf("we_pulses[%0d]", g), 16'(we_cnt[g]), {15'd0, e.we});
    end
    if (e.we) checkOutput("we_cycle", 16'(we_at), 16'd2);
  endtask

  task automatic runTxn(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    rsp_ready = 1'b1;
    applyStimulus(we, addr, wdata);
    #1 checkOutput("req_ready", {13'd0, req_ready}, 16'h0007);
    @(negedge clk);
    req_valid = 1'b0;
    collectResponses(1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) model[i] = 16'hFFFF;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'd0;
    req_wdata = 16'd0;
    rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", {13'd0, req_ready}, 16'd0);
    checkOutput("rst_rsp_valid", {13'd0, rsp_valid}, 16'd0);
    checkOutput("rst_mem_we", {13'd0, mem_we}, 16'd0);
    checkOutput("rst_rsp_err", {13'd0, rsp_err}, 16'd0);
    checkOutput("rst_rsp_data", rsp_data[1], 16'd0);
    checkOutput("rst_mar", mar[1], 16'd0);
    checkOutput("rst_mdr", mdr[1], 16'd0);
    reset = 1'b1;
    @(negedge clk);

    runTxn(1'b1, 16'h0010, 16'h1234);
    checkOutput("mem_0x10", gen_dut[1].mem[16], 16'h1234);
    runTxn(1'b0, 16'h0010, 16'h0000);

    // Response held for five cycles while a new request waits on the inputs.
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; (c < 20) && (rsp_valid != '1); c++) @(negedge clk);
    checkOutput("hold_valid", {13'd0, rsp_valid}, 16'h0007);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0030;
    req_wdata = 16'h5A5A;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("hold_req_ready", {13'd0, req_ready}, 16'd0);
      checkOutput("hold_rsp_data", rsp_data[1], sb[0].data);
      checkOutput("hold_mar", mar[1], 16'h0010);
    end
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("held_data[%0d]", g), rsp_data[g], sb[0].data);
      checkOutput($sformatf("held_err[%0d]", g), {15'd0, rsp_err[g]}, {15'd0, sb[0].err});
    end
    void'(sb.pop_front());
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_ready", {13'd0, req_ready}, 16'h0007);
    checkOutput("release_mar", mar[1], 16'h0010);
    applyStimulus(1'b1, 16'h0030, 16'h5A5A);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("accept_mar", mar[1], 16'h0030);
    collectResponses(1);
    runTxn(1'b0, 16'h0030, 16'h0000);

    runTxn(1'b1, 16'h0100, 16'hABCD);

    // Reset dropped in the ACCESS cycle of the WAIT_STATES=1 instance.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 16'h0020;
    req_wdata = 16'h7777;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_we", {15'd0, mem_we[1]}, 16'd1);
    reset = 1'b0;
    #1 checkOutput("reset_we_gate", {15'd0, mem_we[1]}, 16'd0);
    @(negedge clk);
    checkOutput("mem_0x20_kept", gen_dut[1].mem[32], 16'hFFFF);
    checkOutput("mid_rst_mar", mar[1], 16'd0);
    checkOutput("mid_rst_mdr", mdr[1], 16'd0);
    checkOutput("mid_rst_data", rsp_data[1], 16'd0);
    checkOutput("mid_rst_err", {15'd0, rsp_err[1]}, 16'd0);
    checkOutput("mid_rst_ready", {13'd0, req_ready}, 16'd0);
    repeat (2) @(negedge clk);
    checkOutput("mid_rst_valid", {13'd0, rsp_valid}, 16'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_valid", {13'd0, rsp_valid}, 16'd0);

    runTxn(1'b0, 16'h0010, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
